sint10_12_mac_accumulator: RTL and testbench

Streaming multiply-accumulate stage that produces the signed 10.12 fixed-point samples consumed by the sint10_12-to-fp16 converter. Each input beat is a uint8 pixel and a signed 1.12 coefficient. The block multiplies them, sums the products over a window delimited by `last_i`, and saturates the sum to 22 bits. It emits one 22-bit sample with a one-cycle `valid_o` per window and sits directly upstream of the converter.

---
 rtl/fixed_point_pkg.sv | 14 +
 rtl/sint10_12_saturator.sv | 29 ++
 rtl/sint10_12_mac_accumulator.sv | 125 ++++++++++++
 tb/tb_sint10_12_mac_accumulator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Fixed-point constants and types shared by the sint10_12 MAC accumulator,
// the sint10_12-to-fp16 converter and later stages.
package fixed_point_pkg;

    localparam int SINT10_12_WIDTH     = 22;
    localparam int FRAC_BITS           = 12;
    localparam int COEFF_WIDTH_DEFAULT = 14;

    localparam logic [SINT10_12_WIDTH-1:0] SINT10_12_MAX = 22'h1FFFFF;
    localparam logic [SINT10_12_WIDTH-1:0] SINT10_12_MIN = 22'h200000;

    typedef logic [SINT10_12_WIDTH-1:0] sint10_12_t;

endpackage

// File: rtl/sint10_12_saturator.sv
// Combinational clamp of a wide signed accumulator onto the signed 10.12 range,
// flagging when clamping occurred.
module sint10_12_saturator
    import fixed_point_pkg::*;
#(
    parameter int ACC_WIDTH = 26
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output sint10_12_t           sat_val_o,
    output logic                 sat_o
);

    // The value fits when every bit from the 22-bit sign position upward agrees.
    logic [ACC_WIDTH-SINT10_12_WIDTH:0] w_upper;
    logic                               w_fits;

    assign w_upper = acc_i[ACC_WIDTH-1:SINT10_12_WIDTH-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);

    always_comb begin
        sat_val_o = acc_i[SINT10_12_WIDTH-1:0];
        sat_o     = 1'b0;
        if (!w_fits) begin
            sat_o     = 1'b1;
            sat_val_o = acc_i[ACC_WIDTH-1] ? SINT10_12_MIN : SINT10_12_MAX;
        end
    end

endmodule

// File: rtl/sint10_12_mac_accumulator.sv
// Three-stage streaming MAC: uint8 pixel x signed 1.12 coefficient, summed per
// window (last_i or MAX_TAPS beats) and saturated to signed 10.12.
module sint10_12_mac_accumulator
    import fixed_point_pkg::*;
#(
    parameter int MAX_TAPS    = 16,
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEFAULT,
    parameter int ACC_WIDTH   = SINT10_12_WIDTH + $clog2(MAX_TAPS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             pixel_i,
    input  logic [COEFF_WIDTH-1:0] coeff_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic [21:0]            sint10_12_o,
    output logic                   valid_o,
    output logic                   sat_o,
    output logic                   taps_err_o
);

    localparam int TAP_W = $clog2(MAX_TAPS);
    localparam int PIX_EXT_W   = SINT10_12_WIDTH - 8;
    localparam int COEFF_EXT_W = SINT10_12_WIDTH - COEFF_WIDTH;
    localparam int ACC_EXT_W   = ACC_WIDTH - SINT10_12_WIDTH;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(MAX_TAPS - 1);

    // Stage 1 registers
    logic [7:0]             r_s1_pixel;
    logic [COEFF_WIDTH-1:0] r_s1_coeff;
    logic                   r_s1_valid;
    logic                   r_s1_last;

    // Stage 2 registers
    sint10_12_t r_s2_prod;
    logic       r_s2_valid;
    logic       r_s2_last;

    // Stage 3 state and output registers
    logic [ACC_WIDTH-1:0] r_acc;
    logic [TAP_W-1:0]     r_tap_cnt;
    sint10_12_t           r_out;
    logic                 r_valid_o;
    logic                 r_sat;
    logic                 r_taps_err;

    logic signed [SINT10_12_WIDTH-1:0] w_pix_ext;
    logic signed [SINT10_12_WIDTH-1:0] w_coeff_ext;
    logic signed [SINT10_12_WIDTH-1:0] w_product;
    logic        [ACC_WIDTH-1:0]       w_acc_next;
    logic                              w_close;
    sint10_12_t                        w_sat_val;
    logic                              w_sat;

    always_ff @(posedge clk_i) begin
        r_s1_pixel <= pixel_i;
        r_s1_coeff <= coeff_i;
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= valid_i;
            r_s1_last  <= valid_i & last_i;
        end
    end

    // 255 x (-2.0 .. +1.9998) always fits in 22 bits, so a 22-bit product is exact.
    assign w_pix_ext   = {{PIX_EXT_W{1'b0}}, r_s1_pixel};
    assign w_coeff_ext = {{COEFF_EXT_W{r_s1_coeff[COEFF_WIDTH-1]}}, r_s1_coeff};
    assign w_product   = w_pix_ext * w_coeff_ext;

    always_ff @(posedge clk_i) begin
        r_s2_prod <= w_product;
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    assign w_acc_next = r_acc + {{ACC_EXT_W{r_s2_prod[SINT10_12_WIDTH-1]}}, r_s2_prod};
    assign w_close    = r_s2_valid & (r_s2_last | (r_tap_cnt == LAST_TAP));

    sint10_12_saturator #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_saturator (
        .acc_i     (w_acc_next),
        .sat_val_o (w_sat_val),
        .sat_o     (w_sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc      <= '0;
            r_tap_cnt  <= '0;
            r_out      <= '0;
            r_valid_o  <= 1'b0;
            r_sat      <= 1'b0;
            r_taps_err <= 1'b0;
        end else begin
            r_valid_o  <= 1'b0;
            r_sat      <= 1'b0;
            r_taps_err <= 1'b0;
            if (w_close) begin
                r_out      <= w_sat_val;
                r_valid_o  <= 1'b1;
                r_sat      <= w_sat;
                r_taps_err <= ~r_s2_last;
                r_acc      <= '0;
                r_tap_cnt  <= '0;
            end else if (r_s2_valid) begin
                r_acc     <= w_acc_next;
                r_tap_cnt <= r_tap_cnt + TAP_W'(1);
            end
        end
    end

    assign sint10_12_o = r_out;
    assign valid_o     = r_valid_o;
    assign sat_o       = r_sat;
    assign taps_err_o  = r_taps_err;

endmodule

// File: tb/tb_sint10_12_mac_accumulator.sv
// Bench for the sint10_12 MAC accumulator: directed cases plus random windows,
// compared every cycle against an integer window-sum model.
module tb_sint10_12_mac_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  pixel_i = '0;
    logic [13:0] coeff_i = '0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic [21:0] sint10_12_o;
    logic        valid_o;
    logic        sat_o;
    logic        taps_err_o;

    sint10_12_mac_accumulator dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pixel_i     (pixel_i),
        .coeff_i     (coeff_i),
        .valid_i     (valid_i),
        .last_i      (last_i),
        .sint10_12_o (sint10_12_o),
        .valid_o     (valid_o),
        .sat_o       (sat_o),
        .taps_err_o  (taps_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [21:0] data;
        bit          sat;
        bit          terr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    longint      m_sum = 0;
    int          m_cnt = 0;
    logic [21:0] m_held = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, act, exp_v);
        end
    endtask

    // Drive one input cycle; valid beats update the window-sum model.
    task automatic beat(input int pix, input int coef, input bit v, input bit l);
        longint prod;
        exp_t   e;
        @(negedge clk_i);
        #1;
        rst_i   = 1'b0;
        pixel_i = pix[7:0];
        coeff_i = coef[13:0];
        valid_i = v;
        last_i  = l;
        if (v) begin
            prod  = longint'(pix[7:0]) * ((coef[13:0] >= 8192) ? longint'(coef[13:0]) - 16384 : longint'(coef[13:0]));
            m_sum = m_sum + prod;
            m_cnt = m_cnt + 1;
            if (l || m_cnt == 16) begin
                e.cyc = cyc + 3;
                if (m_sum > 64'sd2097151) begin
                    e.data = 22'h1FFFFF;
                    e.sat  = 1'b1;
                end else if (m_sum < -64'sd2097152) begin
                    e.data = 22'h200000;
                    e.sat  = 1'b1;
                end else begin
                    e.data = m_sum[21:0];
                    e.sat  = 1'b0;
                end
                e.terr = !l;
                q.push_back(e);
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        q.delete();
        m_sum  = 0;
        m_cnt  = 0;
        m_held = '0;
    endtask

    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            chk("rst_data", 32'(sint10_12_o), 32'h0);
            chk("rst_valid", 32'(valid_o), 32'h0);
            chk("rst_sat", 32'(sat_o), 32'h0);
            chk("rst_terr", 32'(taps_err_o), 32'h0);
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("strobe_valid", 32'(valid_o), 32'h1);
            chk("strobe_data", 32'(sint10_12_o), 32'(q[0].data));
            chk("strobe_sat", 32'(sat_o), 32'(q[0].sat));
            chk("strobe_terr", 32'(taps_err_o), 32'(q[0].terr));
            m_held = q[0].data;
            void'(q.pop_front());
        end else begin
            chk("idle_valid", 32'(valid_o), 32'h0);
            chk("idle_sat", 32'(sat_o), 32'h0);
            chk("idle_terr", 32'(taps_err_o), 32'h0);
            chk("hold_data", 32'(sint10_12_o), 32'(m_held));
        end
    end

    initial begin
        int n_gap;
        repeat (3) @(negedge clk_i);
        idle(2);

        // single beat 255 x 1.0
        beat(255, 'h1000, 1'b1, 1'b1);
        idle(4);

        // 100*0.5 + 50*(-1.0) = 0, then back-to-back 1 LSB window
        beat(100, 'h0800, 1'b1, 1'b0);
        beat(50, 'h3000, 1'b1, 1'b1);
        beat(1, 'h0001, 1'b1, 1'b1);
        idle(4);

        // positive and negative saturation
        repeat (2) beat(255, 'h1FFF, 1'b1, 1'b0);
        beat(255, 'h1FFF, 1'b1, 1'b1);
        beat(255, 'h2000, 1'b1, 1'b0);
        beat(255, 'h2000, 1'b1, 1'b1);
        idle(4);

        // forced close at 16 taps, 17th beat opens a fresh window
        repeat (16) beat(1, 'h1000, 1'b1, 1'b0);
        beat(1, 'h1000, 1'b1, 1'b1);
        idle(4);

        // reset mid-window drops in-flight beats
        beat(3, 'h1000, 1'b1, 1'b0);
        beat(3, 'h1000, 1'b1, 1'b0);
        do_reset();
        idle(3);
        beat(2, 'h1000, 1'b1, 1'b1);
        idle(4);

        // gaps with stray last while valid is low
        for (int b = 0; b < 4; b++) begin
            beat(10 + b, 'h0400 + b, 1'b1, b == 3);
            if (b != 3) begin
                beat(0, 0, 1'b0, 1'b1);
                beat(0, 0, 1'b0, 1'b0);
                beat(0, 0, 1'b0, 1'b1);
            end
        end
        idle(4);

        // random traffic, occasionally long windows and extreme coefficients
        for (int i = 0; i < 600; i++) begin
            n_gap = $urandom_range(0, 3);
            if (($urandom_range(0, 7)) == 0)
                beat($urandom_range(200, 255), ($urandom_range(0, 1) != 0) ? 'h1FFF : 'h2000,
                     1'b1, ($urandom_range(0, 9) == 0));
            else
                beat($urandom_range(0, 255), $urandom_range(0, 16383),
                     (n_gap != 0), ($urandom_range(0, 5) == 0));
        end
        beat(1, 'h1000, 1'b1, 1'b1);
        idle(6);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
